// File: rtl/mem_master_pkg.sv
// Shared definitions for mem_master: FSM state encodings, default widths and the ack-match helper.
// Building with MEM_TIMEOUT_EN adds a WAIT-state timeout (mem_timeout_ctr) that reports through rsp_err.
package mem_master_pkg;

  localparam int MEM_ADDR_W = 32'sd32;
  localparam int MEM_DATA_W = 32'sd32;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  // Only the ack that matches the outstanding direction completes an access.
  function automatic logic ack_taken(input logic is_write, input logic rd_ack, input logic wr_ack);
    return is_write ? wr_ack : rd_ack;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating WAIT-cycle counter for mem_master; only compiled when MEM_TIMEOUT_EN is defined.
// expired goes high on the LIMIT-th enabled cycle after clear and stays high until the next clear.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int LIMIT = 32'sd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 32'sd1) ? $clog2(LIMIT) : 32'sd1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 32'sd1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step up until LAST and hold there.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule
`endif

// File: rtl/mem_master.sv
// mem_master: turns a valid/ready command into one readReq/writeReq pulse, waits for the ack, strobes rsp_valid.
// Define MEM_TIMEOUT_EN to bound WAIT with mem_timeout_ctr; otherwise rsp_err is always 0.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = 32'sd255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramOut,
  output logic              readReq,
  output logic              writeReq,
  input  logic [DATA_W-1:0] ramValue,
  input  logic              readAck,
  input  logic              writeAck
);

  mem_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_s;

`ifdef MEM_TIMEOUT_EN
  logic tmo_clear_s;
  logic tmo_enable_s;

  assign tmo_clear_s  = (state_q == MEM_REQ);
  assign tmo_enable_s = (state_q == MEM_WAIT);

  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear_s),
    .enable  (tmo_enable_s),
    .expired (timeout_s)
  );
`else
  logic unused_timeout_cfg_s;

  assign timeout_s            = 1'b0;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES == 32'sd0);
`endif

  // Next-state and registered-output logic; request lines are only ever raised on the accept edge.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (cmd_valid) begin
          state_d  = MEM_REQ;
          write_d  = cmd_write;
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          rd_req_d = ~cmd_write;
          wr_req_d = cmd_write;
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_REQ: begin
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (ack_taken(write_q, readAck, writeAck)) begin
          state_d     = MEM_IDLE;
          rsp_valid_d = 1'b1;
          if (!write_q) begin
            rdata_d = ramValue;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_s) begin
          state_d     = MEM_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
    ready_d = (state_d == MEM_IDLE);
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MEM_IDLE;
      write_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      ready_q     <= 1'b1;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = rsp_err_q;
  assign ramAddress = addr_q;
  assign ramOut     = wdata_q;
  assign readReq    = rd_req_q;
  assign writeReq   = wr_req_q;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: byte-RAM responder with stall injection, table-driven commands and an in-order scoreboard.
module tb_mem_master;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
    int          lat;
    int          stall;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
    int          lat;
    int          t0;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_write, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, ramAddress, ramOut, ramValue;
  logic        readReq, writeReq, readAck, writeAck;

  logic [7:0]  ram [256];
  logic        resp_pend, resp_wr, resp_rack, resp_wack, resp_mute;
  logic        stray_rack, stray_wack;
  logic [31:0] resp_data;
  logic [7:0]  resp_a;
  int          resp_cnt, resp_stall;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[6];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, req_cnt = 0, acc_cnt = 0, rsp_cnt = 0, low_cnt = 0;
  int   last_acc = 0, prev_acc = 0;

  mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ramAddress(ramAddress), .ramOut(ramOut), .readReq(readReq), .writeReq(writeReq),
    .ramValue(ramValue), .readAck(readAck), .writeAck(writeAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ramValue = resp_data;
  assign readAck  = resp_rack | stray_rack;
  assign writeAck = resp_wack | stray_wack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Responder: sees a request, waits resp_stall cycles, then does the byte access and pulses the ack.
  always @(posedge clk) begin
    resp_rack <= 1'b0;
    resp_wack <= 1'b0;
    if (resp_pend) begin
      if (resp_cnt == 0) begin
        resp_pend <= 1'b0;
        resp_a     = ramAddress[7:0];
        if (resp_wr) begin
          ram[resp_a]         <= ramOut[7:0];
          ram[resp_a + 8'd1]  <= ramOut[15:8];
          ram[resp_a + 8'd2]  <= ramOut[23:16];
          ram[resp_a + 8'd3]  <= ramOut[31:24];
          resp_wack           <= 1'b1;
        end else begin
          resp_data <= {ram[resp_a + 8'd3], ram[resp_a + 8'd2], ram[resp_a + 8'd1], ram[resp_a]};
          resp_rack <= 1'b1;
        end
      end else begin
        resp_cnt <= resp_cnt - 1;
      end
    end
    if ((readReq || writeReq) && !resp_mute) begin
      resp_pend <= 1'b1;
      resp_wr   <= writeReq;
      resp_cnt  <= resp_stall;
    end
  end

  // Monitor: request-pulse rules, address/data stability at the ack, and scoreboard compare on rsp_valid.
  always @(negedge clk) begin
    if (reset) begin
      if (!cmd_ready) low_cnt++;
      if (readReq || writeReq) begin
        req_cnt++;
        check("req_exclusive", {31'd0, readReq & writeReq}, 32'd0);
        check("ready_low_in_req", {31'd0, cmd_ready}, 32'd0);
      end
      if ((resp_rack || resp_wack) && sb_q.size() > 0) begin
        check("addr_stable", ramAddress, sb_q[0].addr);
        if (resp_wack) check("wdata_stable", ramOut, sb_q[0].wdata);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.exp);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
          if (mon_e.lat >= 0) check("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        end
      end
    end
  end

  // Called at a negedge; returns two negedges after the accept edge so the responder has latched its stall.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input logic err, input int lat, input int stall);
    int  n;
    sb_t e;
    resp_stall = stall;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = a;
    cmd_wdata  = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.wr = wr; e.addr = a; e.wdata = d; e.exp = exp; e.err = err; e.lat = lat; e.t0 = cyc + 1;
    prev_acc = last_acc;
    last_acc = cyc + 1;
    sb_q.push_back(e);
    acc_cnt++;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_strobes", {28'd0, readReq, writeReq, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_addr", ramAddress, 32'd0);
    check("rst_wdata", ramOut, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, q0, l0;
    logic [7:0] ba;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    ram[8'h10] = 8'h11; ram[8'h11] = 8'h22; ram[8'h12] = 8'h33; ram[8'h13] = 8'h44;
    ram[8'h14] = 8'h55; ram[8'h15] = 8'h66; ram[8'h16] = 8'h77; ram[8'h17] = 8'h88;
    for (int i = 0; i < 8; i++) ram[8'h30 + i] = 8'hA0 + 8'(i);

    vecs[0] = '{1'b0, 32'h10, 32'h0,        32'h44332211, 1'b0, 3, 0};
    vecs[1] = '{1'b1, 32'h20, 32'hDEADBEEF, 32'h44332211, 1'b0, 3, 0};
    vecs[2] = '{1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
    vecs[3] = '{1'b0, 32'h00, 32'h0,        32'h03020100, 1'b0, 5, 2};
    vecs[4] = '{1'b1, 32'h24, 32'hCAFEF00D, 32'h03020100, 1'b0, 4, 1};
    vecs[5] = '{1'b0, 32'h24, 32'h0,        32'hCAFEF00D, 1'b0, 3, 0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    stray_rack = 1'b0; stray_wack = 1'b0; resp_mute = 1'b0; resp_stall = 0;
    resp_pend = 1'b0; resp_wr = 1'b0; resp_cnt = 0; resp_data = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clk);

    // Single reads and writes with and without stalls.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].err, vecs[i].lat, vecs[i].stall);
      cmd_valid = 1'b0;
      wait_drain();
      if (vecs[i].wr) begin
        ba = vecs[i].addr[7:0];
        check("ram_bytes_le", {ram[ba + 8'd3], ram[ba + 8'd2], ram[ba + 8'd1], ram[ba]}, vecs[i].wdata);
      end
    end
    check("ram20_byte0", {24'd0, ram[8'h20]}, 32'h000000EF);

    // Back-to-back reads with cmd_valid held.
    r0 = rsp_cnt; q0 = req_cnt; l0 = low_cnt;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 32'(i * 4), 32'd0, {8'(i * 4 + 3), 8'(i * 4 + 2), 8'(i * 4 + 1), 8'(i * 4)}, 1'b0, 3, 0);
      if (i > 0) check("b2b_spacing", 32'(last_acc - prev_acc), 32'd4);
    end
    cmd_valid = 1'b0;
    wait_drain();
    check("b2b_rsp_count", 32'(rsp_cnt - r0), 32'd4);
    check("b2b_req_count", 32'(req_cnt - q0), 32'd4);
    check("b2b_ready_low", 32'(low_cnt - l0), 32'd12);

    // Stray readAck while idle, then a stray writeAck during a read WAIT.
    stray_rack = 1'b1;
    @(negedge clk);
    stray_rack = 1'b0;
    @(negedge clk);
    check("stray_idle_rsp", {31'd0, rsp_valid}, 32'd0);
    check("stray_idle_ready", {31'd0, cmd_ready}, 32'd1);
    send(1'b0, 32'h14, 32'd0, 32'h88776655, 1'b0, 6, 3);
    stray_wack = 1'b1;
    @(negedge clk);
    stray_wack = 1'b0;
    cmd_valid = 1'b0;
    wait_drain();

    // Reset in the middle of a read WAIT; the responder's late ack lands in IDLE.
    send(1'b0, 32'h30, 32'd0, 32'hA3A2A1A0, 1'b0, 6, 3);
    cmd_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    r0 = rsp_cnt;
    repeat (6) @(negedge clk);
    check("late_ack_dropped", 32'(rsp_cnt - r0), 32'd0);
    send(1'b0, 32'h34, 32'd0, 32'hA7A6A5A4, 1'b0, 3, 0);
    cmd_valid = 1'b0;
    wait_drain();

    // Silent responder.
    resp_mute = 1'b1;
`ifdef MEM_TIMEOUT_EN
    send(1'b0, 32'h40, 32'd0, 32'hA7A6A5A4, 1'b1, 9, 0);
    cmd_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    check("idle_after_timeout", {31'd0, cmd_ready}, 32'd1);
`else
    send(1'b0, 32'h40, 32'd0, 32'hA7A6A5A4, 1'b0, -1, 0);
    cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("no_timeout_pending", 32'(sb_q.size()), 32'd1);
    check("no_timeout_waiting", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif
    resp_mute = 1'b0;

    check("req_pulses", 32'(req_cnt), 32'(acc_cnt));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
